// File: rtl/solver_core_scheduler_if.sv
// Requester/core control bundle for solver_core_scheduler.
// master = scheduler side, slave = requesters plus solver core.
interface solver_core_scheduler_if #(
    parameter int N_REQ = 2
) ();
    localparam int OWNER_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]   req_i;
    logic [N_REQ-1:0]   gnt_o;
    logic [OWNER_W-1:0] owner_o;
    logic               busy_o;
    logic               core_start_o;
    logic               core_done_i;
    logic               core_abort_o;
    logic [N_REQ-1:0]   done_o;
    logic               timeout_o;

    modport master (
        input  req_i, core_done_i,
        output gnt_o, owner_o, busy_o, core_start_o, core_abort_o, done_o, timeout_o
    );

    modport slave (
        output req_i, core_done_i,
        input  gnt_o, owner_o, busy_o, core_start_o, core_abort_o, done_o, timeout_o
    );
endinterface

// File: rtl/solver_core_scheduler.sv
// Round-robin time-sharing of one solver core: grant, config window, start, wait done, release.
// Optional run watchdog enabled by defining SOLVER_TIMEOUT_EN.
`ifndef M_COUNT
`define M_COUNT 2
`endif

module solver_core_scheduler #(
    parameter int N_REQ       = `M_COUNT,
    parameter int SETUP_CYC   = 4,
    parameter int TIMEOUT_CYC = 4096,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   resetb,
    solver_core_scheduler_if.master bus
);
    localparam int OWNER_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [N_REQ-1:0] ONE_HOT0   = N_REQ'(1);
`ifdef SOLVER_TIMEOUT_EN
    // Abort is registered one cycle ahead so it is visible while cnt == TIMEOUT_CYC-1.
    localparam logic [CNT_W-1:0] TMO_ARM    = CNT_W'(TIMEOUT_CYC - 2);
`endif

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_RUN     = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [OWNER_W-1:0] rr_r, rr_s;
    logic [OWNER_W-1:0] owner_r, owner_s;
    logic [N_REQ-1:0]   gnt_r, gnt_s;
    logic [N_REQ-1:0]   done_r, done_s;
    logic               busy_r, busy_s;
    logic               start_r, start_s;
    logic               abort_r, abort_s;
    logic               timeout_r, timeout_s;
    logic [OWNER_W-1:0] rr_after_s;

    // First pending requester at or after ptr, wrapping; lowest offset wins.
    function automatic logic [OWNER_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                   input logic [OWNER_W-1:0] ptr);
        logic [OWNER_W-1:0] idx;
        rr_pick = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = OWNER_W'((int'(ptr) + i) % N_REQ);
            if (req[idx]) begin
                rr_pick = idx;
            end else begin
                rr_pick = rr_pick;
            end
        end
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        sat_inc = (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    assign rr_after_s = (owner_r == OWNER_W'(N_REQ - 1)) ? OWNER_W'(0) : owner_r + OWNER_W'(1);

    // Next-state and next-output decode for the job FSM.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        rr_s      = rr_r;
        owner_s   = owner_r;
        gnt_s     = gnt_r;
        start_s   = 1'b0;
        done_s    = {N_REQ{1'b0}};
        abort_s   = 1'b0;
        timeout_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_s = {CNT_W{1'b0}};
                if (|bus.req_i) begin
                    state_s = ST_SETUP;
                    owner_s = rr_pick(bus.req_i, rr_r);
                    gnt_s   = ONE_HOT0 << owner_s;
                end else begin
                    gnt_s   = {N_REQ{1'b0}};
                end
            end
            ST_SETUP: begin
                if (!bus.req_i[owner_r]) begin
                    state_s = ST_IDLE;
                    gnt_s   = {N_REQ{1'b0}};
                    cnt_s   = {CNT_W{1'b0}};
                end else if (cnt_r == SETUP_LAST) begin
                    state_s = ST_RUN;
                    start_s = 1'b1;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s   = sat_inc(cnt_r);
                end
            end
            ST_RUN: begin
                cnt_s = sat_inc(cnt_r);
                if (bus.core_done_i) begin
                    state_s = ST_RELEASE;
                    done_s  = gnt_r;
                    rr_s    = rr_after_s;
`ifdef SOLVER_TIMEOUT_EN
                end else if (timeout_r) begin
                    state_s = ST_RELEASE;
                    done_s  = gnt_r;
                    rr_s    = rr_after_s;
                end else if (cnt_r == TMO_ARM) begin
                    abort_s   = 1'b1;
                    timeout_s = 1'b1;
`endif
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_RELEASE: begin
                state_s = ST_IDLE;
                gnt_s   = {N_REQ{1'b0}};
                cnt_s   = {CNT_W{1'b0}};
            end
            default: begin
                state_s = ST_IDLE;
                gnt_s   = {N_REQ{1'b0}};
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State, counter, pointer and all output registers.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            rr_r      <= {OWNER_W{1'b0}};
            owner_r   <= {OWNER_W{1'b0}};
            gnt_r     <= {N_REQ{1'b0}};
            done_r    <= {N_REQ{1'b0}};
            busy_r    <= 1'b0;
            start_r   <= 1'b0;
            abort_r   <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            rr_r      <= rr_s;
            owner_r   <= owner_s;
            gnt_r     <= gnt_s;
            done_r    <= done_s;
            busy_r    <= busy_s;
            start_r   <= start_s;
            abort_r   <= abort_s;
            timeout_r <= timeout_s;
        end
    end

    assign bus.gnt_o        = gnt_r;
    assign bus.owner_o      = owner_r;
    assign bus.busy_o       = busy_r;
    assign bus.core_start_o = start_r;
    assign bus.done_o       = done_r;
    assign bus.core_abort_o = abort_r;
    assign bus.timeout_o    = timeout_r;
endmodule

// File: tb/tb_solver_core_scheduler.sv
// Directed bench for solver_core_scheduler with a cycle-age job model compared every cycle.
module tb_solver_core_scheduler;
    localparam int N  = 2;
    localparam int SC = 4;
    localparam int TC = 8;
`ifdef SOLVER_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetb = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    solver_core_scheduler_if #(.N_REQ(N)) bus ();

    solver_core_scheduler #(
        .N_REQ(N), .SETUP_CYC(SC), .TIMEOUT_CYC(TC), .CNT_W(16)
    ) dut (
        .clk(clk), .resetb(resetb), .bus(bus)
    );

    always #5 clk = ~clk;

    // Model: a job is described by its age in cycles since the grant became visible.
    bit m_busy;
    int m_owner, m_age, m_end, m_abort, m_rr;

    function automatic int pick(input logic [N-1:0] r, input int from);
        for (int k = 0; k < N; k++) begin
            if (r[(from + k) % N]) return (from + k) % N;
        end
        return from;
    endfunction

    always @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            m_busy <= 1'b0; m_owner <= 0; m_age <= 0; m_end <= 0; m_abort <= 0; m_rr <= 0;
        end else if (!m_busy) begin
            if (|bus.req_i) begin
                m_busy  <= 1'b1;
                m_owner <= pick(bus.req_i, m_rr);
                m_age   <= 1;
                m_end   <= 0;
                m_abort <= 0;
            end
        end else if (m_age == m_end) begin
            m_busy <= 1'b0;
            m_rr   <= (m_owner + 1) % N;
        end else if (m_age <= SC && !bus.req_i[m_owner]) begin
            m_busy <= 1'b0;
        end else begin
            if (m_age > SC && m_end == 0) begin
                if (bus.core_done_i) begin
                    m_end <= m_age + 1;
                end else if (TMO && m_age == SC + TC - 1) begin
                    m_abort <= m_age + 1;
                    m_end   <= m_age + 2;
                end
            end
            m_age <= m_age + 1;
        end
    end

    logic [N-1:0] e_gnt, e_done;
    logic [2*N+5:0] e_vec, a_vec;

    always @(negedge clk) begin
        if (resetb) begin
            e_gnt  = m_busy ? N'(1 << m_owner) : '0;
            e_done = (m_busy && m_age == m_end) ? e_gnt : '0;
            e_vec  = {e_gnt, m_busy ? 1'(m_owner) : 1'b0, m_busy, m_busy && m_age == SC + 1,
                      e_done, m_busy && m_age == m_abort, m_busy && m_age == m_abort};
            a_vec  = {bus.gnt_o, bus.busy_o ? bus.owner_o : 1'b0, bus.busy_o, bus.core_start_o,
                      bus.done_o, bus.core_abort_o, bus.timeout_o};
            n_chk++;
            if (a_vec !== e_vec) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t {gnt,owner,busy,start,done,abort,tmo} got %b expected %b",
                         $time, a_vec, e_vec);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_start();
        int i;
        i = 0;
        while (bus.core_start_o !== 1'b1 && i < 64) begin
            step(1);
            i++;
        end
        if (i >= 64) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_start: no core_start_o within 64 cycles, got 0 expected 1");
        end
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        step(2);
        resetb = 1'b1;
    endtask

    logic [N-1:0] exp2 [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

    initial begin
        bus.req_i = '0;
        bus.core_done_i = 1'b0;
        step(3);
        chk("reset_gnt", 32'(bus.gnt_o), 32'd0);
        chk("reset_busy", 32'(bus.busy_o), 32'd0);
        chk("reset_owner", 32'(bus.owner_o), 32'd0);
        chk("reset_pulses", 32'({bus.core_start_o, bus.done_o, bus.core_abort_o, bus.timeout_o}), 32'd0);
        resetb = 1'b1;

        // single job latency
        bus.req_i = 2'b01;
        step(1);  chk("t1_gnt", 32'(bus.gnt_o), 32'd1);
        step(3);  chk("t1_start_early", 32'(bus.core_start_o), 32'd0);
        step(1);  chk("t1_start", 32'(bus.core_start_o), 32'd1);
        step(15); bus.core_done_i = 1'b1;
        step(1);  bus.core_done_i = 1'b0; bus.req_i = '0;
        chk("t1_done", 32'(bus.done_o), 32'd1);
        chk("t1_gnt_release", 32'(bus.gnt_o), 32'd1);
        step(1);  chk("t1_gnt_low", 32'(bus.gnt_o), 32'd0);

        // round-robin alternation with both requesters held
        do_reset();
        bus.req_i = 2'b11;
        for (int j = 0; j < 4; j++) begin
            wait_start();
            chk("t2_gnt", 32'(bus.gnt_o), 32'(exp2[j]));
            step(10); bus.core_done_i = 1'b1;
            step(1);  bus.core_done_i = 1'b0;
            if (j == 3) bus.req_i = '0;
            chk("t2_done", 32'(bus.done_o), 32'(exp2[j]));
        end
        step(2);

        // withdrawal during setup
        bus.req_i = 2'b10;
        step(1); chk("t3_gnt", 32'(bus.gnt_o), 32'd2);
        step(2); bus.req_i = '0;
        step(1); chk("t3_gnt_drop", 32'(bus.gnt_o), 32'd0);
        chk("t3_busy_drop", 32'(bus.busy_o), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk("t3_quiet", 32'({bus.core_start_o, bus.done_o}), 32'd0);
            step(1);
        end
        bus.req_i = 2'b11;
        step(1); chk("t3_regrant", 32'(bus.gnt_o), 32'd1);
        wait_start();
        step(1); bus.core_done_i = 1'b1;
        step(1); bus.core_done_i = 1'b0; bus.req_i = '0;
        step(2);

        // stray core_done_i in IDLE and in SETUP
        bus.core_done_i = 1'b1;
        step(1); bus.core_done_i = 1'b0;
        chk("t4_idle_busy", 32'(bus.busy_o), 32'd0);
        chk("t4_idle_done", 32'(bus.done_o), 32'd0);
        bus.req_i = 2'b01;
        step(2); bus.core_done_i = 1'b1;
        step(1); bus.core_done_i = 1'b0;
        chk("t4_setup_done", 32'(bus.done_o), 32'd0);
        chk("t4_setup_busy", 32'(bus.busy_o), 32'd1);
        step(2); chk("t4_start", 32'(bus.core_start_o), 32'd1);
        step(1); bus.core_done_i = 1'b1;
        step(1); bus.core_done_i = 1'b0; bus.req_i = '0;
        chk("t4_done", 32'(bus.done_o), 32'd1);
        step(2);

`ifdef SOLVER_TIMEOUT_EN
        // watchdog expiry
        bus.req_i = 2'b01;
        wait_start();
        step(7);
        chk("t5_abort", 32'(bus.core_abort_o), 32'd1);
        chk("t5_timeout", 32'(bus.timeout_o), 32'd1);
        step(1); bus.req_i = '0;
        chk("t5_done", 32'(bus.done_o), 32'd1);
        chk("t5_abort_gone", 32'(bus.core_abort_o), 32'd0);
        step(1); chk("t5_gnt_low", 32'(bus.gnt_o), 32'd0);
        step(1);
        // done arriving just before the watchdog fires wins
        bus.req_i = 2'b01;
        wait_start();
        step(6); bus.core_done_i = 1'b1;
        step(1); bus.core_done_i = 1'b0; bus.req_i = '0;
        chk("t5_win_done", 32'(bus.done_o), 32'd1);
        chk("t5_win_noabort", 32'({bus.core_abort_o, bus.timeout_o}), 32'd0);
        step(2);
`else
        // no watchdog: the job waits indefinitely
        bus.req_i = 2'b01;
        wait_start();
        step(10000);
        chk("t5_still_busy", 32'(bus.busy_o), 32'd1);
        chk("t5_still_gnt", 32'(bus.gnt_o), 32'd1);
        chk("t5_no_abort", 32'({bus.core_abort_o, bus.timeout_o}), 32'd0);
        bus.core_done_i = 1'b1;
        step(1); bus.core_done_i = 1'b0; bus.req_i = '0;
        chk("t5_done", 32'(bus.done_o), 32'd1);
        step(2);
`endif

        // reset in the middle of a job
        bus.req_i = 2'b10;
        wait_start();
        step(3);
        #2 resetb = 1'b0;
        #1;
        chk("t6_gnt", 32'(bus.gnt_o), 32'd0);
        chk("t6_busy", 32'(bus.busy_o), 32'd0);
        chk("t6_pulses", 32'({bus.core_start_o, bus.done_o, bus.core_abort_o, bus.timeout_o}), 32'd0);
        bus.req_i = '0;
        step(1);
        resetb = 1'b1;
        bus.req_i = 2'b11;
        step(1); chk("t6_first_gnt", 32'(bus.gnt_o), 32'd1);
        wait_start();
        step(1); bus.core_done_i = 1'b1;
        step(1); bus.core_done_i = 1'b0; bus.req_i = '0;
        chk("t6_done", 32'(bus.done_o), 32'd1);
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1);
    end
endmodule
